// File: rtl/gtx_ll_tx_arb.sv
// gtx_ll_tx_arb: round-robin LocalLink TX arbiter/framer for the Aurora GTX core.
// Prepends a channel/sequence header, caps payload length, aborts on link loss.
module gtx_ll_tx_arb #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 1024,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_gtp,
  input  logic                     rst_gtp_n,
  input  logic                     channel_up,
  input  logic [NUM_CH*DATA_W-1:0] ch_tx_data,
  input  logic [NUM_CH-1:0]        ch_tx_sof_n,
  input  logic [NUM_CH-1:0]        ch_tx_eof_n,
  input  logic [NUM_CH-1:0]        ch_tx_src_rdy_n,
  output logic [NUM_CH-1:0]        ch_tx_dst_rdy_n,
  output logic [DATA_W-1:0]        gtx_tx_data,
  output logic                     gtx_tx_sof_n,
  output logic                     gtx_tx_eof_n,
  output logic                     gtx_tx_src_rdy_n,
  input  logic                     gtx_tx_dst_rdy_n,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy,
  output logic                     trunc_err,
  output logic                     abort_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DROP
  } state_t;

  state_t r_state, w_next;

  logic [CH_W-1:0]   r_grant, r_last, w_pick, r_out_ch;
  logic [7:0]        r_seq [NUM_CH];
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data, w_hdr, w_g_data;
  logic [7:0]        w_hdr_seq;
  logic r_sof_n, r_eof_n, r_vld;
  logic r_trunc, r_abort;
  logic w_any, w_free, w_leave, w_eof_leave;
  logic w_g_src, w_g_eof, w_acc;
  logic w_trunc, w_abort;

  assign w_free      = !r_vld || !gtx_tx_dst_rdy_n;
  assign w_leave     = r_vld && !gtx_tx_dst_rdy_n;
  assign w_eof_leave = w_leave && !r_eof_n;

  assign w_g_src  = !ch_tx_src_rdy_n[r_grant];
  assign w_g_eof  = !ch_tx_eof_n[r_grant];
  assign w_g_data = ch_tx_data[r_grant*DATA_W +: DATA_W];
  assign w_acc    = (r_state == S_DATA) && w_g_src && w_free;

  // Descending scan so the nearest channel after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (!ch_tx_src_rdy_n[(int'(r_last) + k) % NUM_CH] &&
          !ch_tx_sof_n[(int'(r_last) + k) % NUM_CH]) begin
        w_any  = 1'b1;
        w_pick = CH_W'((int'(r_last) + k) % NUM_CH);
      end
    end
  end

  // Bypass a same-channel eof leaving this cycle so the header seq is current.
  assign w_hdr_seq = r_seq[r_grant] +
                     {7'd0, w_eof_leave && (r_out_ch == r_grant)};

  always_comb begin
    w_hdr             = '0;
    w_hdr[7:0]        = w_hdr_seq;
    w_hdr[8 +: CH_W]  = r_grant;
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    w_trunc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (channel_up && w_any) w_next = S_HDR;
      end
      S_HDR: begin
        if (!channel_up) begin
          w_abort = 1'b1;
          w_next  = S_DROP;
        end else if (w_free) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!channel_up) begin
          w_abort = 1'b1;
          w_next  = (w_acc && w_g_eof) ? S_IDLE : S_DROP;
        end else if (w_acc) begin
          if (w_g_eof) begin
            w_next = S_IDLE;
          end else if (r_cnt == LAST) begin
            w_trunc = 1'b1;
            w_next  = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_g_src && w_g_eof) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ch_tx_dst_rdy_n = '1;
    if (r_state == S_DATA) begin
      ch_tx_dst_rdy_n[r_grant] = !w_free;
    end else if (r_state == S_DROP) begin
      ch_tx_dst_rdy_n[r_grant] = 1'b0;
    end
  end

  always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
    if (!rst_gtp_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_last   <= CH_W'(NUM_CH - 1);
      r_cnt    <= '0;
      r_data   <= '0;
      r_sof_n  <= 1'b1;
      r_eof_n  <= 1'b1;
      r_vld    <= 1'b0;
      r_out_ch <= '0;
      r_trunc  <= 1'b0;
      r_abort  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_seq[i] <= '0;
    end else begin
      r_state <= w_next;
      r_trunc <= w_trunc;
      r_abort <= w_abort;
      if ((r_state == S_IDLE) && (w_next == S_HDR)) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
      if ((r_state == S_HDR) && (w_next == S_DATA)) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_abort) begin
        r_vld <= 1'b0;
      end else if ((r_state == S_HDR) && w_free) begin
        r_data   <= w_hdr;
        r_sof_n  <= 1'b0;
        r_eof_n  <= 1'b1;
        r_vld    <= 1'b1;
        r_out_ch <= r_grant;
      end else if (w_acc) begin
        r_data   <= w_g_data;
        r_sof_n  <= 1'b1;
        r_eof_n  <= !(w_g_eof || w_trunc);
        r_vld    <= 1'b1;
        r_out_ch <= r_grant;
      end else if (w_leave) begin
        r_vld <= 1'b0;
      end
      if (w_eof_leave) r_seq[r_out_ch] <= r_seq[r_out_ch] + 8'd1;
    end
  end

  assign gtx_tx_data      = r_data;
  assign gtx_tx_sof_n     = r_sof_n;
  assign gtx_tx_eof_n     = r_eof_n;
  assign gtx_tx_src_rdy_n = !r_vld;
  assign grant_ch         = r_grant;
  assign busy             = (r_state != S_IDLE);
  assign trunc_err        = r_trunc;
  assign abort_err        = r_abort;

endmodule

// File: tb/tb_gtx_ll_tx_arb.sv
// tb_gtx_ll_tx_arb: directed bench for gtx_ll_tx_arb.
// Queue-driven channel sources and an output monitor; tasks check inline.
module tb_gtx_ll_tx_arb;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int MAXW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof_n;
    logic          eof_n;
  } word_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            channel_up;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]  ch_sof_n, ch_eof_n, ch_src_n, ch_dst_n;
  logic [DW-1:0]   gtx_data;
  logic            gtx_sof_n, gtx_eof_n, gtx_src_n, gtx_dst_n;
  logic [1:0]      grant;
  logic            busy, trunc, abort;

  word_t chq [NCH][$];
  word_t outq[$];
  word_t exp_q[$];
  word_t prev, cur;
  logic [NCH-1:0] acc;
  bit   prev_stall = 0;
  bit   bp_en = 0;
  bit   ok;
  int   n_vec = 0, n_err = 0;
  int   n_trunc = 0, n_abort = 0, n_stall = 0;

  gtx_ll_tx_arb #(
    .NUM_CH(NCH), .DATA_W(DW), .MAX_WORDS(MAXW)
  ) dut (
    .clk_gtp(clk),
    .rst_gtp_n(rst_n),
    .channel_up(channel_up),
    .ch_tx_data(ch_data),
    .ch_tx_sof_n(ch_sof_n),
    .ch_tx_eof_n(ch_eof_n),
    .ch_tx_src_rdy_n(ch_src_n),
    .ch_tx_dst_rdy_n(ch_dst_n),
    .gtx_tx_data(gtx_data),
    .gtx_tx_sof_n(gtx_sof_n),
    .gtx_tx_eof_n(gtx_eof_n),
    .gtx_tx_src_rdy_n(gtx_src_n),
    .gtx_tx_dst_rdy_n(gtx_dst_n),
    .grant_ch(grant),
    .busy(busy),
    .trunc_err(trunc),
    .abort_err(abort)
  );

  always #5 clk = ~clk;

  // Sources and monitor: sample on negedge, update after posedge.
  always begin
    @(negedge clk);
    acc = ~ch_src_n & ~ch_dst_n;
    cur = word_t'({gtx_data, gtx_sof_n, gtx_eof_n});
    if (rst_n) begin
      if (!gtx_src_n && !gtx_dst_n) outq.push_back(cur);
      if (trunc) n_trunc++;
      if (abort) n_abort++;
      if (prev_stall && (gtx_src_n || cur != prev)) n_stall++;
      prev_stall = !gtx_src_n && gtx_dst_n;
      prev = cur;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) void'(chq[i].pop_front());
      if (chq[i].size() > 0) begin
        ch_data[i*DW +: DW] = chq[i][0].d;
        ch_sof_n[i] = chq[i][0].sof_n;
        ch_eof_n[i] = chq[i][0].eof_n;
        ch_src_n[i] = 1'b0;
      end else begin
        ch_data[i*DW +: DW] = '0;
        ch_sof_n[i] = 1'b1;
        ch_eof_n[i] = 1'b1;
        ch_src_n[i] = 1'b1;
      end
    end
    gtx_dst_n = bp_en ? 1'($urandom_range(1, 0)) : 1'b0;
  end

  task automatic push_frame(input int ch, input int n, input logic [DW-1:0] base);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.d     = base + DW'(k);
      w.sof_n = (k != 0);
      w.eof_n = (k != n - 1);
      chq[ch].push_back(w);
    end
  endtask

  task automatic add_exp(input logic [DW-1:0] d, input logic s, input logic e);
    exp_q.push_back(word_t'({d, s, e}));
  endtask

  task automatic wait_idle(input int lim, output bit done);
    bit empty;
    done = 0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      empty = 1;
      for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) empty = 0;
      if (empty && !busy && gtx_src_n) begin
        done = 1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic start_case();
    outq.delete();
    exp_q.delete();
    n_trunc = 0;
    n_abort = 0;
    n_stall = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({gtx_src_n, gtx_sof_n, gtx_eof_n} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 111", {gtx_src_n, gtx_sof_n, gtx_eof_n});
    end
    n_vec++;
    if (gtx_data !== 16'h0000 || grant !== 2'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%0d want 0000/0", gtx_data, grant);
    end
    n_vec++;
    if ({busy, trunc, abort} !== 3'b000 || ch_dst_n !== 4'hF) begin
      n_err++;
      $display("FAIL reset_misc: got %b/%h want 000/f", {busy, trunc, abort}, ch_dst_n);
    end
    rst_n = 1'b1;
    channel_up = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || gtx_src_n !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b%b want 01", busy, gtx_src_n);
    end
  endtask

  task automatic test_single();
    start_case();
    push_frame(0, 1, 16'h1234);
    add_exp(16'h0000, 1'b0, 1'b1);
    add_exp(16'h1234, 1'b1, 1'b0);
    wait_idle(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL single_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
    n_vec++;
    if (grant !== 2'd0) begin n_err++; $display("FAIL single_grant: got %0d want 0", grant); end
  endtask

  task automatic test_round_robin();
    start_case();
    push_frame(1, 3, 16'h1100);
    push_frame(3, 3, 16'h3300);
    push_frame(1, 3, 16'h1110);
    push_frame(3, 3, 16'h3310);
    add_exp(16'h0100, 0, 1); add_exp(16'h1100, 1, 1);
    add_exp(16'h1101, 1, 1); add_exp(16'h1102, 1, 0);
    add_exp(16'h0300, 0, 1); add_exp(16'h3300, 1, 1);
    add_exp(16'h3301, 1, 1); add_exp(16'h3302, 1, 0);
    add_exp(16'h0101, 0, 1); add_exp(16'h1110, 1, 1);
    add_exp(16'h1111, 1, 1); add_exp(16'h1112, 1, 0);
    add_exp(16'h0301, 0, 1); add_exp(16'h3310, 1, 1);
    add_exp(16'h3311, 1, 1); add_exp(16'h3312, 1, 0);
    wait_idle(400, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rr_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rr_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL rr_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
    n_vec++;
    if (grant !== 2'd3) begin n_err++; $display("FAIL rr_grant: got %0d want 3", grant); end
  endtask

  task automatic test_truncation();
    start_case();
    push_frame(2, 10, 16'h2200);
    push_frame(2, 1, 16'h2299);
    add_exp(16'h0200, 0, 1);
    for (int k = 0; k < MAXW; k++) add_exp(16'h2200 + 16'(k), 1, (k != MAXW - 1));
    add_exp(16'h0201, 0, 1);
    add_exp(16'h2299, 1, 0);
    wait_idle(400, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL trunc_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL trunc_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL trunc_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
    n_vec++;
    if (n_trunc != 1 || n_abort != 0) begin
      n_err++;
      $display("FAIL trunc_pulse: got %0d/%0d want 1/0", n_trunc, n_abort);
    end
  endtask

  task automatic test_backpressure();
    start_case();
    bp_en = 1;
    push_frame(3, MAXW, 16'h3A00);
    add_exp(16'h0302, 0, 1);
    for (int k = 0; k < MAXW; k++) add_exp(16'h3A00 + 16'(k), 1, (k != MAXW - 1));
    wait_idle(600, ok);
    bp_en = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL bp_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
    n_vec++;
    if (n_stall != 0 || n_trunc != 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d/%0d want 0/0", n_stall, n_trunc);
    end
  endtask

  task automatic test_link_down();
    bit seen;
    start_case();
    push_frame(1, 5, 16'h1500);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (chq[1].size() == 3) begin seen = 1; break; end
    end
    channel_up = 1'b0;
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL ld_word2: got 0 want 1"); end
    add_exp(16'h0102, 0, 1);
    add_exp(16'h1500, 1, 1);
    add_exp(16'h1501, 1, 1);
    wait_idle(300, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ld_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL ld_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL ld_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
    n_vec++;
    if (n_abort != 1 || n_trunc != 0) begin
      n_err++;
      $display("FAIL ld_pulse: got %0d/%0d want 1/0", n_abort, n_trunc);
    end
    start_case();
    push_frame(1, 1, 16'h15AA);
    repeat (6) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || outq.size() != 0) begin
      n_err++;
      $display("FAIL ld_block: got %b/%0d want 0/0", busy, outq.size());
    end
    channel_up = 1'b1;
    add_exp(16'h0102, 0, 1);
    add_exp(16'h15AA, 1, 0);
    wait_idle(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ld_restore_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL ld_restore_len: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++) begin
      n_vec++;
      if (outq[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL ld_restore_w%0d: got %h want %h", k, outq[k], exp_q[k]);
      end
    end
  endtask

  // ch0 already carried one frame, so 256 more make 257 in total.
  task automatic test_seq_wrap();
    start_case();
    for (int k = 0; k < 256; k++) push_frame(0, 1, 16'(k));
    wait_idle(5000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap_timeout: got 0 want 1"); end
    n_vec++;
    if (outq.size() != 512) begin
      n_err++;
      $display("FAIL wrap_len: got %0d want 512", outq.size());
    end
    if (outq.size() == 512) begin
      n_vec++;
      if (outq[0] !== word_t'({16'h0001, 1'b0, 1'b1})) begin
        n_err++;
        $display("FAIL wrap_first: got %h want %h", outq[0], word_t'({16'h0001, 1'b0, 1'b1}));
      end
      n_vec++;
      if (outq[508] !== word_t'({16'h00FF, 1'b0, 1'b1})) begin
        n_err++;
        $display("FAIL wrap_ff: got %h want %h", outq[508], word_t'({16'h00FF, 1'b0, 1'b1}));
      end
      n_vec++;
      if (outq[510] !== word_t'({16'h0000, 1'b0, 1'b1})) begin
        n_err++;
        $display("FAIL wrap_00: got %h want %h", outq[510], word_t'({16'h0000, 1'b0, 1'b1}));
      end
      n_vec++;
      if (outq[511] !== word_t'({16'h00FF, 1'b1, 1'b0})) begin
        n_err++;
        $display("FAIL wrap_last: got %h want %h", outq[511], word_t'({16'h00FF, 1'b1, 1'b0}));
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    channel_up = 1'b0;
    ch_data    = '0;
    ch_sof_n   = '1;
    ch_eof_n   = '1;
    ch_src_n   = '1;
    gtx_dst_n  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_backpressure();
    test_link_down();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
